// File: rtl/shake_length_tracker.sv
// SHAKE absorb-path message-length tracker: per-word valid bits, block position,
// last-word/last-block status and padding-block insertion for two selectable rates.
// Optional abort input: define SHAKE_LEN_ABORT_EN.
module shake_length_tracker #(
  parameter int WIDTH = 32,
  parameter int W     = 64,
  parameter int RATE0 = 1344,
  parameter int RATE1 = 1088,
  localparam int WPB0    = RATE0 / W,
  localparam int WPB1    = RATE1 / W,
  localparam int WPB_MAX = (WPB0 > WPB1) ? WPB0 : WPB1,
  localparam int IDX_W   = $clog2(WPB_MAX),
  localparam int VB_W    = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             len_valid,
  output logic             len_ready,
  input  logic [WIDTH-1:0] len_in,
  input  logic             mode,
  input  logic             step,
`ifdef SHAKE_LEN_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] remaining,
  output logic [IDX_W-1:0] word_idx,
  output logic [VB_W-1:0]  valid_bits,
  output logic             last_word,
  output logic             last_block,
  output logic             block_end,
  output logic             pad_block,
  output logic             busy,
  output logic             done
);

  if ((RATE0 % W) != 0 || (RATE1 % W) != 0) begin : g_rate_chk
    $error("shake_length_tracker: RATE0/RATE1 must be multiples of W");
  end

  typedef enum logic [1:0] {IDLE, COUNT, PAD, DONE} state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] rem_q, rem_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic             mode_q, mode_n;

  logic [IDX_W-1:0] last_idx;
  logic [WIDTH:0]   words_left, bits_left;
  logic             c_last_word, c_last_block, c_block_end, c_extra;
  logic [VB_W-1:0]  c_vb;

  assign last_idx   = mode_q ? IDX_W'(WPB1 - 1) : IDX_W'(WPB0 - 1);
  // Free space in the rest of the block; one extra bit so the product never wraps.
  assign words_left = (WIDTH+1)'(mode_q ? WPB1 : WPB0) - (WIDTH+1)'(idx_q);
  assign bits_left  = words_left * (WIDTH+1)'(W);

  assign c_last_word  = rem_q <= WIDTH'(W);
  assign c_vb         = c_last_word ? VB_W'(rem_q) : VB_W'(W);
  assign c_last_block = {1'b0, rem_q} <= (bits_left - (WIDTH+1)'(8));
  assign c_block_end  = idx_q == last_idx;
  // Final word fills the block past its last free byte: padding spills into a new block.
  assign c_extra      = c_last_word && c_block_end && (c_vb > VB_W'(W - 8));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '1;
      idx_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      rem_q   <= rem_n;
      idx_q   <= idx_n;
      mode_q  <= mode_n;
    end
  end

  always_comb begin
    state_n = state_q;
    rem_n   = rem_q;
    idx_n   = idx_q;
    mode_n  = mode_q;
    case (state_q)
      IDLE: if (len_valid) begin
        rem_n   = len_in;
        mode_n  = mode;
        idx_n   = '0;
        state_n = COUNT;
      end
      COUNT: if (step) begin
        rem_n = rem_q - WIDTH'(c_vb);
        idx_n = c_block_end ? '0 : idx_q + IDX_W'(1);
        if (c_last_word) state_n = c_extra ? PAD : DONE;
      end
      PAD: if (step) begin
        idx_n = c_block_end ? '0 : idx_q + IDX_W'(1);
        if (c_block_end) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
`ifdef SHAKE_LEN_ABORT_EN
    if (abort) begin
      state_n = IDLE;
      rem_n   = '1;
    end
`endif
  end

  always_comb begin
    len_ready  = state_q == IDLE;
    busy       = state_q != IDLE;
    done       = state_q == DONE;
    remaining  = rem_q;
    word_idx   = idx_q;
    valid_bits = '0;
    last_word  = 1'b0;
    last_block = 1'b0;
    block_end  = 1'b0;
    pad_block  = 1'b0;
    case (state_q)
      COUNT: begin
        valid_bits = c_vb;
        last_word  = c_last_word;
        last_block = c_last_block;
        block_end  = c_block_end;
      end
      PAD: begin
        remaining  = '0;
        last_block = 1'b1;
        block_end  = c_block_end;
        pad_block  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/shake_length_tracker.md
# shake_length_tracker

Message-length tracker for the SHAKE absorb path, replacing the single-rate down-counter. It accepts a total message length in bits through a valid/ready handshake and supports two run-time selectable rates (SHAKE128 / SHAKE256). It tracks the remaining bits and the word position within the current rate block, and reports per-word valid-bit counts, last-word and last-block status, and the need for an extra padding-only block. It sits between the input-length register and the absorb/padding controller.

## Interface
- WIDTH, 32, width of length and remaining counters (bits of length)
- W, 64, lane/word width in bits
- RATE0, 1344, rate in bits for mode 0 (SHAKE128); must be a multiple of W
- RATE1, 1088, rate in bits for mode 1 (SHAKE256); must be a multiple of W
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- len_valid  in  1  length offered
- len_ready  out  1  tracker idle, accepts a length
- len_in  in  WIDTH  total message length in bits
- mode  in  1  rate select, sampled with len_in
- step  in  1  downstream consumed the current word
- remaining  out  WIDTH  message bits not yet consumed
- word_idx  out  $clog2(max(RATE0,RATE1)/W)  word index within the current block
- valid_bits  out  $clog2(W+1)  message bits in the current word, min(remaining, W)
- last_word  out  1  current word holds the final message bits
- last_block  out  1  current block is the final absorbed block
- block_end  out  1  current word is the last word of the rate block
- pad_block  out  1  current block is padding only
- busy  out  1  state is not IDLE
- done  out  1  single-cycle completion pulse
- abort  in  1  present only with SHAKE_LEN_ABORT_EN

## Operation
- WPB = RATE/W for the latched mode: 21 for mode 0, 17 for mode 1. Non-multiple rates fail elaboration.
- States: IDLE, COUNT, PAD, DONE.
- IDLE:
  - len_ready=1.
  - On len_valid: remaining<=len_in, latch mode, word_idx<=0, go to COUNT. len_in=0 is legal.
- COUNT, on step:
  - remaining <= remaining - valid_bits.
  - word_idx increments, wrapping WPB-1 -> 0.
  - If last_word: go to PAD when extra is true, otherwise go to DONE.
- Outputs in COUNT:
  - last_word = remaining <= W.
  - valid_bits = min(remaining, W).
  - bits_left = (WPB - word_idx) * W.
  - last_block = remaining <= bits_left - 8. Padding needs at least one free byte.
  - extra = last_word && word_idx == WPB-1 && valid_bits > W-8.
  - block_end = word_idx == WPB-1.
- PAD:
  - word_idx restarts at 0.
  - Outputs: pad_block=1, last_block=1, valid_bits=0, last_word=0, remaining=0.
  - step advances word_idx; step at word_idx==WPB-1 goes to DONE.
- DONE:
  - done=1 for one cycle, then IDLE.
  - remaining holds 0.
- Ignored inputs:
  - step is ignored in IDLE and DONE.
  - len_valid is ignored outside IDLE.
- Gating: all status outputs are gated by state. In IDLE and DONE, last_word, last_block, block_end, pad_block and valid_bits are 0.
- Width rules:
  - Subtraction never underflows, because valid_bits <= remaining.
  - bits_left arithmetic uses WIDTH+1 bits.
  - bits_left - 8 never goes negative, because W >= 8.
- Reset values: state=IDLE, remaining='1, word_idx=0, mode=0, len_ready=1, busy=0, all other outputs 0.

## Timing
- All state is in registers; outputs are combinational from registers (Moore).
- Length acceptance: the handshake completes on the edge where len_valid && len_ready. State is COUNT, and outputs are valid, in the following cycle.
- Step: one word per step per cycle. Back-to-back steps are supported with zero bubble.
- Block-to-block: no extra latency. Permutation stalls are expressed by holding step low.
- Completion: the final step moves to DONE on that edge, done is high for that one cycle, and len_ready returns one cycle later.
- Reset mid-operation: immediate return to the reset values, with no done.

## Configuration
- SHAKE_LEN_ABORT_EN defined:
  - Adds the abort input.
  - abort high in any state forces IDLE and remaining='1 on the next edge, with no done pulse.
  - abort has priority over step and len_valid in the same cycle.
- SHAKE_LEN_ABORT_EN undefined: port absent; the only way out of an operation is completion or rst.

## Test plan
- mode0, len_in=200, step every cycle:
  - valid_bits reads 64, 64, 64, 8; last_word=1 on the 4th word; last_block=1 throughout.
  - The 4th step goes to DONE; done pulses once; then IDLE.
- mode1, len_in=1088:
  - 17 COUNT words with last_block=0; word 16 has block_end=1 and valid_bits=64, so the tracker enters PAD.
  - 17 PAD words with pad_block=1, then done.
- mode0, len_in=1336: 21 words, last word valid_bits=56, last_block=1 from the start, no PAD, done after step 21.
- len_in=0: COUNT with last_word=1, valid_bits=0, last_block=1; one step produces done.
- mode0, len_in=1400 with step gapped randomly:
  - word_idx wraps 20 -> 0 with block_end=1 at 20; remaining=56 and last_block=1 after the wrap.
  - One more step produces done; counts are unaffected by the gaps.
- Robustness:
  - rst asserted mid-COUNT returns all reset values.
  - With SHAKE_LEN_ABORT_EN: abort with step in the same cycle returns to IDLE, remaining='1, and no done.
  - len_valid during COUNT is ignored.
